// File: rtl/dmux_1xn_reg.sv
// Registered 1-to-N demultiplexer with a valid/ready handshake on the input and on each output slot.
// Define DMUX_BCAST_EN to add the broadcast port b, which loads one word into every channel at once.
module dmux_1xn_reg #(
    parameter int W  = 1,
    parameter int N  = 16,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [SW-1:0]  s,
`ifdef DMUX_BCAST_EN
    input  logic           b,
`endif
    output logic [N*W-1:0] y,
    output logic [N-1:0]   y_valid,
    input  logic [N-1:0]   y_ready,
    output logic           err
);

    localparam logic [SW:0] N_EXT = (SW+1)'(N);

    logic [N-1:0][W-1:0] y_q, y_d;
    logic [N-1:0]        valid_q, valid_d;
    logic                err_q, err_d;

    logic [N-1:0] free_s;
    logic [N-1:0] sel_oh_s;
    logic [N-1:0] load_s;
    logic         in_range_s;
    logic         bcast_s;
    logic         accept_s;

`ifdef DMUX_BCAST_EN
    assign bcast_s = b;
`else
    assign bcast_s = 1'b0;
`endif

    // A slot can take a word if it is empty or is being drained in this same cycle
    assign free_s     = ~valid_q | y_ready;
    assign in_range_s = ({1'b0, s} < N_EXT);

    // One-hot decode of the select; an out-of-range select matches no channel
    always_comb begin
        sel_oh_s = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SW'(k)) begin
                sel_oh_s[k] = 1'b1;
            end else begin
                sel_oh_s[k] = 1'b0;
            end
        end
    end

    // Input ready: never depends on in_valid, so the producer sees no loop through it
    always_comb begin
        in_ready = 1'b1;
        if (bcast_s) begin
            in_ready = &free_s;
        end else if (in_range_s) begin
            in_ready = |(sel_oh_s & free_s);
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept_s = in_valid & in_ready;
    assign load_s   = {N{accept_s}} & ({N{bcast_s}} | sel_oh_s);

    // Per-slot next state: a load wins over a drain so back-to-back words insert no bubble
    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        for (int k = 0; k < N; k++) begin
            if (load_s[k]) begin
                y_d[k]     = a;
                valid_d[k] = 1'b1;
            end else if (valid_q[k] && y_ready[k]) begin
                y_d[k]     = '0;
                valid_d[k] = 1'b0;
            end else begin
                y_d[k]     = y_q[k];
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Sticky error: a word with an unmapped select was accepted and thrown away
    always_comb begin
        err_d = err_q;
        if (accept_s && !bcast_s && !in_range_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset empties every slot immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign y       = y_q;
    assign y_valid = valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dmux_1xn_reg.sv
// Directed bench for dmux_1xn_reg: a 16-channel instance for the main scenarios and a
// 10-channel instance for out-of-range selects. Broadcast scenario is built with DMUX_BCAST_EN.
module tb_dmux_1xn_reg;

    logic         clk;
    logic         rst_n;

    logic         in_valid16, in_ready16, err16;
    logic [7:0]   a16;
    logic [3:0]   s16;
    logic [127:0] y16;
    logic [15:0]  y_valid16, y_ready16;

    logic         in_valid10, in_ready10, err10;
    logic [7:0]   a10;
    logic [3:0]   s10;
    logic [79:0]  y10;
    logic [9:0]   y_valid10, y_ready10;
`ifdef DMUX_BCAST_EN
    logic         b16;
    logic         b10;
`endif

    int n_checks;
    int n_fail;

    dmux_1xn_reg #(.W(8), .N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .s(s16),
`ifdef DMUX_BCAST_EN
        .b(b16),
`endif
        .y(y16), .y_valid(y_valid16), .y_ready(y_ready16), .err(err16)
    );

    dmux_1xn_reg #(.W(8), .N(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
        .a(a10), .s(s10),
`ifdef DMUX_BCAST_EN
        .b(b10),
`endif
        .y(y10), .y_valid(y_valid10), .y_ready(y_ready10), .err(err10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (y16 !== 128'h0 || y_valid16 !== 16'h0 || err16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset16: y=%h y_valid=%h err=%b, want all 0", y16, y_valid16, err16);
        end
        n_checks++;
        if (y10 !== 80'h0 || y_valid10 !== 10'h0 || err10 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset10: y=%h y_valid=%h err=%b, want all 0", y10, y_valid10, err10);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready16 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready16);
        end
    endtask

    task automatic test_sweep();
        y_ready16 = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid16 = 1'b1;
            s16 = 4'(i);
            a16 = 8'h10 + 8'(i);
            #1;
            n_checks++;
            if (in_ready16 !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_ready s=%0d: in_ready=%b want 1", i, in_ready16);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (y_valid16 !== (16'h1 << i) || y16[i*8 +: 8] !== (8'h10 + 8'(i))) begin
                n_fail++;
                $display("FAIL sweep_out s=%0d: y_valid=%h data=%h want %h / %h",
                         i, y_valid16, y16[i*8 +: 8], 16'h1 << i, 8'h10 + 8'(i));
            end
        end
        @(negedge clk);
        in_valid16 = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (y_valid16 !== 16'h0 || y16 !== 128'h0) begin
            n_fail++;
            $display("FAIL sweep_drain: y_valid=%h y=%h want 0", y_valid16, y16);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        y_ready16 = 16'hFFF7;
        in_valid16 = 1'b1; s16 = 4'd3; a16 = 8'hA5;
        @(posedge clk);
        #1;
        @(negedge clk);
        a16 = 8'h5A;
        #1;
        n_checks++;
        if (in_ready16 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_low: in_ready=%b want 0", in_ready16);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (y16[31:24] !== 8'hA5 || y_valid16 !== 16'h0008) begin
            n_fail++;
            $display("FAIL bp_hold: slot3=%h y_valid=%h want A5 / 0008", y16[31:24], y_valid16);
        end
        @(negedge clk);
        y_ready16 = 16'hFFFF;
        #1;
        n_checks++;
        if (in_ready16 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_rise: in_ready=%b want 1", in_ready16);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (y16[31:24] !== 8'h5A || y_valid16 !== 16'h0008) begin
            n_fail++;
            $display("FAIL bp_refill: slot3=%h y_valid=%h want 5A / 0008", y16[31:24], y_valid16);
        end
        @(negedge clk);
        in_valid16 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_isolation();
        @(negedge clk);
        y_ready16 = 16'hFFF7;
        in_valid16 = 1'b1; s16 = 4'd3; a16 = 8'hA5;
        @(posedge clk);
        #1;
        @(negedge clk);
        s16 = 4'd7; a16 = 8'h77;
        #1;
        n_checks++;
        if (in_ready16 !== 1'b1) begin
            n_fail++;
            $display("FAIL iso_ready: in_ready=%b want 1", in_ready16);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (y_valid16 !== 16'h0088 || y16[31:24] !== 8'hA5 || y16[63:56] !== 8'h77) begin
            n_fail++;
            $display("FAIL iso_out: y_valid=%h slot3=%h slot7=%h want 0088 / A5 / 77",
                     y_valid16, y16[31:24], y16[63:56]);
        end
        @(negedge clk);
        in_valid16 = 1'b0;
        y_ready16 = 16'hFFFF;
        @(posedge clk);
        #1;
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        y_ready10 = 10'h000;
        in_valid10 = 1'b1; s10 = 4'd2; a10 = 8'h22;
        @(posedge clk);
        #1;
        @(negedge clk);
        s10 = 4'd12; a10 = 8'hFF;
        #1;
        n_checks++;
        if (in_ready10 !== 1'b1 || err10 !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_ready: in_ready=%b err=%b want 1 / 0", in_ready10, err10);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (err10 !== 1'b1 || y_valid10 !== 10'h004 || y10 !== {56'h0, 8'h22, 16'h0}) begin
            n_fail++;
            $display("FAIL oor_effect: err=%b y_valid=%h y=%h want 1 / 004 / slot2=22 only",
                     err10, y_valid10, y10);
        end
        @(negedge clk);
        in_valid10 = 1'b0;
        y_ready10 = 10'h3FF;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err10 !== 1'b1 || y_valid10 !== 10'h000) begin
            n_fail++;
            $display("FAIL oor_sticky: err=%b y_valid=%h want 1 / 000", err10, y_valid10);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        y_ready16 = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            in_valid16 = 1'b1; s16 = 4'(i); a16 = 8'hC0 + 8'(i);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        in_valid16 = 1'b0;
        #1;
        n_checks++;
        if (y_valid16 !== 16'h001F || y16[39:32] !== 8'hC4) begin
            n_fail++;
            $display("FAIL mid_fill: y_valid=%h slot4=%h want 001F / C4", y_valid16, y16[39:32]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (y_valid16 !== 16'h0 || y16 !== 128'h0 || err10 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: y_valid=%h y=%h err10=%b want 0 / 0 / 0",
                     y_valid16, y16, err10);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s16 = 4'd3;
        #1;
        n_checks++;
        if (in_ready16 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ready: in_ready=%b want 1", in_ready16);
        end
        y_ready16 = 16'hFFFF;
    endtask

`ifdef DMUX_BCAST_EN
    task automatic test_broadcast();
        @(negedge clk);
        y_ready16 = 16'hFFFB;
        b16 = 1'b0; in_valid16 = 1'b1; s16 = 4'd2; a16 = 8'h11;
        @(posedge clk);
        #1;
        @(negedge clk);
        b16 = 1'b1; a16 = 8'h3C; s16 = 4'd9;
        #1;
        n_checks++;
        if (in_ready16 !== 1'b0) begin
            n_fail++;
            $display("FAIL bc_ready_low: in_ready=%b want 0", in_ready16);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (y_valid16 !== 16'h0004 || y16[23:16] !== 8'h11) begin
            n_fail++;
            $display("FAIL bc_stall: y_valid=%h slot2=%h want 0004 / 11", y_valid16, y16[23:16]);
        end
        @(negedge clk);
        y_ready16 = 16'hFFFF;
        #1;
        n_checks++;
        if (in_ready16 !== 1'b1) begin
            n_fail++;
            $display("FAIL bc_ready_high: in_ready=%b want 1", in_ready16);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (y_valid16 !== 16'hFFFF || y16 !== {16{8'h3C}}) begin
            n_fail++;
            $display("FAIL bc_out: y_valid=%h y=%h want FFFF / all 3C", y_valid16, y16);
        end
        @(negedge clk);
        in_valid16 = 1'b0; b16 = 1'b0;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid16 = 1'b0; a16 = 8'h0; s16 = 4'h0; y_ready16 = 16'hFFFF;
        in_valid10 = 1'b0; a10 = 8'h0; s10 = 4'h0; y_ready10 = 10'h3FF;
`ifdef DMUX_BCAST_EN
        b16 = 1'b0;
        b10 = 1'b0;
`endif
        test_reset();
        test_sweep();
        test_backpressure();
        test_isolation();
        test_out_of_range();
        test_reset_mid();
`ifdef DMUX_BCAST_EN
        test_broadcast();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
